// File: rtl/out_port_arb.sv
// Round-robin arbiter for one output port: grants one requester, refuses the
// others, and holds ownership until the owner signals done plus a short gap.
module out_port_arb #(
    parameter int PORTNUM = 16,
    parameter int GAP_CYC = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic [PORTNUM-1:0]         i_req,
    input  logic                       i_done,
    output logic                       o_port_ready,
    output logic [PORTNUM-1:0]         o_resp,
    output logic [PORTNUM-1:0]         o_nresp,
    output logic [$clog2(PORTNUM)-1:0] o_owner,
    output logic                       o_owner_vld
);

    localparam int IW = $clog2(PORTNUM);
    localparam int CW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam bit HAS_GAP = (GAP_CYC > 0);
    localparam logic [PORTNUM-1:0] ONE_HOT0 = {{(PORTNUM-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_GAP
    } state_t;

    state_t            state_q, state_d;
    logic [IW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [IW-1:0]     owner_d;
    logic              owner_vld_d;
    logic              ready_d;
    logic [PORTNUM-1:0] resp_d, nresp_d;

    logic [IW-1:0]     win;
    logic              win_found;
    logic [IW-1:0]     scan_idx;

    // Rotating priority search: first requester at or above ptr, wrapping.
    always_comb begin
        win       = '0;
        win_found = 1'b0;
        scan_idx  = '0;
        for (int i = 0; i < PORTNUM; i++) begin
            scan_idx = ptr_q + IW'(i);
            if (!win_found && i_req[scan_idx]) begin
                win       = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        cnt_d       = cnt_q;
        owner_d     = o_owner;
        owner_vld_d = o_owner_vld;
        ready_d     = o_port_ready;
        resp_d      = '0;
        nresp_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (win_found) begin
                    resp_d      = ONE_HOT0 << win;
                    nresp_d     = i_req & ~(ONE_HOT0 << win);
                    owner_d     = win;
                    owner_vld_d = 1'b1;
                    ready_d     = 1'b0;
                    ptr_d       = win + 1'b1;
                    state_d     = S_BUSY;
                end
            end
            S_BUSY: begin
                // The owner's own request may linger; only the others are refused.
                nresp_d = i_req & ~(ONE_HOT0 << o_owner);
                if (i_done) begin
                    owner_vld_d = 1'b0;
                    owner_d     = '0;
                    if (HAS_GAP) begin
                        cnt_d   = CW'(GAP_CYC - 1);
                        state_d = S_GAP;
                    end else begin
                        ready_d = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_GAP: begin
                if (cnt_q == '0) begin
                    ready_d = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments only.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= S_IDLE;
            ptr_q        <= '0;
            cnt_q        <= '0;
            o_owner      <= '0;
            o_owner_vld  <= 1'b0;
            o_port_ready <= 1'b1;
            o_resp       <= '0;
            o_nresp      <= '0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            o_owner      <= owner_d;
            o_owner_vld  <= owner_vld_d;
            o_port_ready <= ready_d;
            o_resp       <= resp_d;
            o_nresp      <= nresp_d;
        end
    end

endmodule
